// File: rtl/regfile_pkg.sv
// Shared definitions for the integer register file.
// Holds the default index/data widths used by decode and writeback, the
// register-count derivation and the slice-offset helper for packed port buses.
package regfile_pkg;

  localparam int unsigned RF_ADDR_WIDTH = 5;
  localparam int unsigned RF_DATA_WIDTH = 32;

  // Number of architectural registers addressable with an index of this width.
  function automatic int unsigned nregs(input int unsigned addr_width);
    return 32'd1 << addr_width;
  endfunction

  // LSB of port 'port' inside a packed bus of 'width'-bit fields.
  function automatic int unsigned slice_lsb(input int unsigned port, input int unsigned width);
    return port * width;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard for the register file.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   iss_valid   mark iss_rd busy this cycle
//   iss_rd      destination index being issued
//   flush       clear every busy bit next cycle (wins over issue)
//   wen, waddr  writeback ports; a write clears its destination's busy bit
//   raddr       read indices looked up in the busy state
//   busy_vec    registered busy bits
//   raw_busy    per-read-port busy lookup, no masking applied
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = RF_ADDR_WIDTH,
  parameter int unsigned NUM_RD     = 2,
  parameter int unsigned NUM_WR     = 1,
  parameter bit          ZERO_REG   = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         iss_valid,
  input  logic [ADDR_WIDTH-1:0]        iss_rd,
  input  logic                         flush,
  input  logic [NUM_WR-1:0]            wen,
  input  logic [NUM_WR*ADDR_WIDTH-1:0] waddr,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] raddr,
  output logic [nregs(ADDR_WIDTH)-1:0] busy_vec,
  output logic [NUM_RD-1:0]            raw_busy
);

  localparam int unsigned NREGS = nregs(ADDR_WIDTH);

  logic [ADDR_WIDTH-1:0] waddr_arr [NUM_WR];
  logic [ADDR_WIDTH-1:0] raddr_arr [NUM_RD];
  logic [NREGS-1:0]      busy_q, busy_d, set_vec, clr_vec;

  for (genvar k = 0; k < NUM_WR; k++) begin : g_wr_unpack
    assign waddr_arr[k] = waddr[slice_lsb(k, ADDR_WIDTH) +: ADDR_WIDTH];
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd_unpack
    assign raddr_arr[i] = raddr[slice_lsb(i, ADDR_WIDTH) +: ADDR_WIDTH];
    assign raw_busy[i]  = busy_q[raddr_arr[i]];
  end

  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (iss_valid) begin
      set_vec[iss_rd] = 1'b1;
    end
    if (ZERO_REG) begin
      set_vec[0] = 1'b0;
    end
    for (int k = 0; k < NUM_WR; k++) begin
      if (wen[k]) begin
        clr_vec[waddr_arr[k]] = 1'b1;
      end
    end
    // Issue after writeback of the same register leaves it busy for the new producer.
    busy_d = flush ? '0 : ((busy_q & ~clr_vec) | set_vec);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy_vec = busy_q;

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port integer register file with integrated busy-bit scoreboard.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   wen/waddr/wdata   NUM_WR synchronous write ports, packed per port
//   raddr/rdata       NUM_RD combinational read ports, packed per port
//   rbusy             per read port: register has an outstanding producer
//   iss_valid/iss_rd  mark a destination busy at issue
//   flush             clear all busy bits, contents untouched
//   busy_vec          raw registered scoreboard state
module regfile_mp_sb
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = RF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = RF_DATA_WIDTH,
  parameter int unsigned NUM_RD     = 2,
  parameter int unsigned NUM_WR     = 1,
  parameter bit          ZERO_REG   = 1'b1,
  parameter bit          BYPASS     = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_WR-1:0]            wen,
  input  logic [NUM_WR*ADDR_WIDTH-1:0] waddr,
  input  logic [NUM_WR*DATA_WIDTH-1:0] wdata,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] raddr,
  output logic [NUM_RD*DATA_WIDTH-1:0] rdata,
  output logic [NUM_RD-1:0]            rbusy,
  input  logic                         iss_valid,
  input  logic [ADDR_WIDTH-1:0]        iss_rd,
  input  logic                         flush,
  output logic [nregs(ADDR_WIDTH)-1:0] busy_vec
);

  localparam int unsigned NREGS = nregs(ADDR_WIDTH);

  logic [ADDR_WIDTH-1:0] waddr_arr [NUM_WR];
  logic [DATA_WIDTH-1:0] wdata_arr [NUM_WR];
  logic [ADDR_WIDTH-1:0] raddr_arr [NUM_RD];
  logic [DATA_WIDTH-1:0] rd_val    [NUM_RD];
  logic [DATA_WIDTH-1:0] rf_q      [NREGS];
  logic [DATA_WIDTH-1:0] rf_d      [NREGS];
  logic [NUM_RD-1:0]     byp_hit;
  logic [NUM_RD-1:0]     raw_busy;

  for (genvar k = 0; k < NUM_WR; k++) begin : g_wr_unpack
    assign waddr_arr[k] = waddr[slice_lsb(k, ADDR_WIDTH) +: ADDR_WIDTH];
    assign wdata_arr[k] = wdata[slice_lsb(k, DATA_WIDTH) +: DATA_WIDTH];
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd_unpack
    assign raddr_arr[i] = raddr[slice_lsb(i, ADDR_WIDTH) +: ADDR_WIDTH];
  end

  // Ascending port order so the highest-index port wins on a collision.
  always_comb begin
    rf_d = rf_q;
    for (int k = 0; k < NUM_WR; k++) begin
      if (wen[k] && !(ZERO_REG && (waddr_arr[k] == '0))) begin
        rf_d[waddr_arr[k]] = wdata_arr[k];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREGS; r++) begin
        rf_q[r] <= '0;
      end
    end else begin
      rf_q <= rf_d;
    end
  end

  regfile_scoreboard #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_RD     (NUM_RD),
    .NUM_WR     (NUM_WR),
    .ZERO_REG   (ZERO_REG)
  ) u_scoreboard (
    .clk       (clk),
    .rst_n     (rst_n),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .flush     (flush),
    .wen       (wen),
    .waddr     (waddr),
    .raddr     (raddr),
    .busy_vec  (busy_vec),
    .raw_busy  (raw_busy)
  );

  always_comb begin
    for (int i = 0; i < NUM_RD; i++) begin
      rd_val[i]  = rf_q[raddr_arr[i]];
      byp_hit[i] = 1'b0;
      if (BYPASS) begin
        for (int k = 0; k < NUM_WR; k++) begin
          if (wen[k] && (waddr_arr[k] == raddr_arr[i])) begin
            rd_val[i]  = wdata_arr[k];
            byp_hit[i] = 1'b1;
          end
        end
      end
      if (ZERO_REG && (raddr_arr[i] == '0)) begin
        rd_val[i] = '0;
      end
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd_out
    assign rdata[slice_lsb(i, DATA_WIDTH) +: DATA_WIDTH] = rd_val[i];
    // A bypassed read already carries the producer's data, so it is not busy.
    assign rbusy[i] = raw_busy[i] & ~byp_hit[i] & ~(ZERO_REG && (raddr_arr[i] == '0));
  end

endmodule

// File: tb/tb_regfile_mp_sb.sv
module tb_regfile_mp_sb;

  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int NR    = 2;
  localparam int NW    = 2;
  localparam int NREGS = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NW-1:0]    wen;
  logic [NW*AW-1:0] waddr;
  logic [NW*DW-1:0] wdata;
  logic [NR*AW-1:0] raddr;
  logic             iss_valid;
  logic [AW-1:0]    iss_rd;
  logic             flush;

  logic [NR*DW-1:0] rdata_bp, rdata_nb;
  logic [NR-1:0]    rbusy_bp, rbusy_nb;
  logic [NREGS-1:0] busy_vec_bp, busy_vec_nb;

  always #5 clk = ~clk;

  regfile_mp_sb #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .NUM_RD     (NR),
    .NUM_WR     (NW),
    .ZERO_REG   (1'b1),
    .BYPASS     (1'b1)
  ) u_dut_bp (
    .clk       (clk),
    .rst_n     (rst_n),
    .wen       (wen),
    .waddr     (waddr),
    .wdata     (wdata),
    .raddr     (raddr),
    .rdata     (rdata_bp),
    .rbusy     (rbusy_bp),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .flush     (flush),
    .busy_vec  (busy_vec_bp)
  );

  regfile_mp_sb #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .NUM_RD     (NR),
    .NUM_WR     (NW),
    .ZERO_REG   (1'b1),
    .BYPASS     (1'b0)
  ) u_dut_nb (
    .clk       (clk),
    .rst_n     (rst_n),
    .wen       (wen),
    .waddr     (waddr),
    .wdata     (wdata),
    .raddr     (raddr),
    .rdata     (rdata_nb),
    .rbusy     (rbusy_nb),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .flush     (flush),
    .busy_vec  (busy_vec_nb)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model state.
  logic [DW-1:0]    m_rf [NREGS];
  logic [NREGS-1:0] m_busy;

  typedef struct {
    string            tag;
    logic [NR*DW-1:0] rd_bp;
    logic [NR*DW-1:0] rd_nb;
    logic [NR-1:0]    rb_bp;
    logic [NR-1:0]    rb_nb;
    logic [NREGS-1:0] bv;
  } exp_t;

  exp_t exp_q[$];

  function automatic logic [DW-1:0] model_read(input logic [AW-1:0] ra, input bit bp);
    logic [DW-1:0] v;
    if (ra == '0) return '0;
    v = m_rf[ra];
    if (bp) begin
      for (int k = 0; k < NW; k++) begin
        if (wen[k] && (waddr[k*AW +: AW] == ra)) v = wdata[k*DW +: DW];
      end
    end
    return v;
  endfunction

  function automatic logic model_busy(input logic [AW-1:0] ra, input bit bp);
    if (ra == '0) return 1'b0;
    if (bp) begin
      for (int k = 0; k < NW; k++) begin
        if (wen[k] && (waddr[k*AW +: AW] == ra)) return 1'b0;
      end
    end
    return m_busy[ra];
  endfunction

  task automatic model_reset();
    for (int r = 0; r < NREGS; r++) m_rf[r] = '0;
    m_busy = '0;
  endtask

  task automatic push_expected(input string tag);
    exp_t e;
    e.tag = tag;
    for (int i = 0; i < NR; i++) begin
      e.rd_bp[i*DW +: DW] = model_read(raddr[i*AW +: AW], 1'b1);
      e.rd_nb[i*DW +: DW] = model_read(raddr[i*AW +: AW], 1'b0);
      e.rb_bp[i]          = model_busy(raddr[i*AW +: AW], 1'b1);
      e.rb_nb[i]          = model_busy(raddr[i*AW +: AW], 1'b0);
    end
    e.bv = m_busy;
    exp_q.push_back(e);
  endtask

  task automatic compare_front();
    exp_t e;
    if (exp_q.size() == 0) begin
      check_eq("scoreboard_empty", 64'd0, 64'd1);
      return;
    end
    e = exp_q.pop_front();
    check_eq({e.tag, ".rdata_bp"}, rdata_bp, e.rd_bp);
    check_eq({e.tag, ".rdata_nb"}, rdata_nb, e.rd_nb);
    check_eq({e.tag, ".rbusy_bp"}, rbusy_bp, e.rb_bp);
    check_eq({e.tag, ".rbusy_nb"}, rbusy_nb, e.rb_nb);
    check_eq({e.tag, ".busy_vec_bp"}, busy_vec_bp, e.bv);
    check_eq({e.tag, ".busy_vec_nb"}, busy_vec_nb, e.bv);
  endtask

  task automatic model_commit();
    logic [NREGS-1:0] clr, set;
    clr = '0;
    set = '0;
    for (int k = 0; k < NW; k++) begin
      if (wen[k]) begin
        clr[waddr[k*AW +: AW]] = 1'b1;
        if (waddr[k*AW +: AW] != '0) m_rf[waddr[k*AW +: AW]] = wdata[k*DW +: DW];
      end
    end
    if (iss_valid && (iss_rd != '0)) set[iss_rd] = 1'b1;
    m_busy = flush ? '0 : ((m_busy & ~clr) | set);
  endtask

  // Inputs are already applied (just after negedge); check, advance one cycle.
  task automatic step(input string tag);
    push_expected(tag);
    #1;
    compare_front();
    model_commit();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    wen       = '0;
    waddr     = '0;
    wdata     = '0;
    raddr     = '0;
    iss_valid = 1'b0;
    iss_rd    = '0;
    flush     = 1'b0;
  endtask

  task automatic set_w(input int k, input logic [AW-1:0] a, input logic [DW-1:0] d);
    wen[k]          = 1'b1;
    waddr[k*AW +: AW] = a;
    wdata[k*DW +: DW] = d;
  endtask

  task automatic set_r(input int i, input logic [AW-1:0] a);
    raddr[i*AW +: AW] = a;
  endtask

  task automatic issue(input logic [AW-1:0] a);
    iss_valid = 1'b1;
    iss_rd    = a;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    model_reset();

    // Held in reset: every index reads zero and idle.
    for (int a = 0; a < NREGS; a++) begin
      @(negedge clk);
      set_r(0, AW'(a));
      set_r(1, AW'(NREGS - 1 - a));
      #1;
      check_eq("rst_rdata_bp", rdata_bp, 64'd0);
      check_eq("rst_rdata_nb", rdata_nb, 64'd0);
      check_eq("rst_rbusy", {rbusy_bp, rbusy_nb}, 64'd0);
      check_eq("rst_busy_vec", busy_vec_bp, 64'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    idle();

    // Basic write then read.
    set_w(0, 5'd5, 32'hDEADBEEF);
    set_r(0, 5'd5);
    set_r(1, 5'd5);
    #1;
    check_eq("byp_x5_same_cycle", rdata_bp[31:0], 64'hDEADBEEF);
    check_eq("nobyp_x5_same_cycle", rdata_nb[31:0], 64'd0);
    step("wr_x5");
    idle();
    set_r(0, 5'd5);
    #1;
    check_eq("rd_x5_bp", rdata_bp[31:0], 64'hDEADBEEF);
    check_eq("rd_x5_nb", rdata_nb[31:0], 64'hDEADBEEF);
    step("rd_x5");

    // Zero register ignores writes.
    idle();
    set_w(0, 5'd0, 32'h1234);
    set_r(0, 5'd0);
    step("wr_x0");
    idle();
    set_r(0, 5'd0);
    #1;
    check_eq("rd_x0", rdata_bp[31:0], 64'd0);
    step("rd_x0");

    // Same-cycle bypass on read port 1.
    idle();
    set_w(0, 5'd7, 32'hA5A5A5A5);
    set_r(1, 5'd7);
    #1;
    check_eq("byp_x7_port1", rdata_bp[63:32], 64'hA5A5A5A5);
    check_eq("nobyp_x7_port1", rdata_nb[63:32], 64'd0);
    step("wr_x7");

    // Two ports hit x3: port 1 wins.
    idle();
    set_w(0, 5'd3, 32'h11);
    set_w(1, 5'd3, 32'h22);
    set_r(0, 5'd3);
    #1;
    check_eq("byp_x3_collide", rdata_bp[31:0], 64'h22);
    step("wr_x3_collide");
    idle();
    set_r(0, 5'd3);
    #1;
    check_eq("rd_x3_collide", rdata_nb[31:0], 64'h22);
    step("rd_x3");

    // Issue x9: busy visible only from the next cycle.
    idle();
    issue(5'd9);
    set_r(0, 5'd9);
    #1;
    check_eq("iss_x9_no_fwd", rbusy_bp[0], 64'd0);
    step("iss_x9");
    idle();
    set_r(0, 5'd9);
    #1;
    check_eq("x9_busy_rbusy", rbusy_bp[0], 64'd1);
    check_eq("x9_busy_vec", busy_vec_bp[9], 64'd1);
    step("x9_busy");

    // Writeback of x9 clears it; bypass hides busy in the same cycle.
    idle();
    set_w(0, 5'd9, 32'h99);
    set_r(0, 5'd9);
    #1;
    check_eq("wb_x9_rbusy_bp", rbusy_bp[0], 64'd0);
    check_eq("wb_x9_rbusy_nb", rbusy_nb[0], 64'd1);
    step("wb_x9");
    idle();
    #1;
    check_eq("x9_cleared", busy_vec_bp[9], 64'd0);
    step("x9_cleared");

    // Issue and writeback together: set wins.
    idle();
    issue(5'd9);
    set_w(1, 5'd9, 32'h98);
    step("iss_wb_x9");
    idle();
    #1;
    check_eq("x9_set_wins", busy_vec_bp[9], 64'd1);
    step("x9_set_wins");

    // Flush overrides a same-cycle issue.
    idle();
    issue(5'd4);
    step("iss_x4");
    idle();
    issue(5'd12);
    step("iss_x12");
    idle();
    #1;
    check_eq("busy_4_9_12", busy_vec_bp, 64'h0000_1210);
    flush = 1'b1;
    issue(5'd4);
    step("flush");
    idle();
    #1;
    check_eq("after_flush", busy_vec_bp, 64'd0);
    step("after_flush");

    // Write after flush: data lands, busy stays clear.
    idle();
    set_w(0, 5'd12, 32'h0BAD_F00D);
    step("wr_after_flush");

    // Randomised traffic over a small index window to force collisions.
    for (int n = 0; n < 300; n++) begin
      idle();
      wen = NW'($urandom_range(0, 3));
      for (int k = 0; k < NW; k++) set_w_bus(k);
      set_r(0, AW'($urandom_range(0, 7)));
      set_r(1, AW'($urandom_range(0, 7)));
      iss_valid = ($urandom_range(0, 2) == 0);
      iss_rd    = AW'($urandom_range(0, 7));
      flush     = ($urandom_range(0, 15) == 0);
      step("rand");
    end

    // Asynchronous reset in the middle of a cycle.
    idle();
    set_w(0, 5'd5, 32'hCAFEF00D);
    issue(5'd6);
    step("pre_reset");
    idle();
    set_r(0, 5'd5);
    set_r(1, 5'd6);
    #2;
    check_eq("pre_reset_x5", rdata_bp[31:0], 64'hCAFEF00D);
    check_eq("pre_reset_x6_busy", busy_vec_bp[6], 64'd1);
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_x5", rdata_bp[31:0], 64'd0);
    check_eq("async_rst_busy_vec", busy_vec_bp, 64'd0);
    check_eq("async_rst_rbusy", {rbusy_bp, rbusy_nb}, 64'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step("post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Random address/data for port k; enable already chosen.
  task automatic set_w_bus(input int k);
    waddr[k*AW +: AW] = AW'($urandom_range(0, 7));
    wdata[k*DW +: DW] = $urandom;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
